code_counter: RTL and testbench
===============================

// Module: code_counter
// PURPOSE
//   Dual 64-bit event counter: one channel counts every enabled clock, the other
//   counts once per PRESCALE enabled clocks. Slt picks the active channel; En gates
//   all counting. Used as a free-running cycle/tick counter with a
//   divided-rate companion output.
// PARAMETERS
//   WIDTH     64  counter width of Output0/Output1 (wrap modulo 2^WIDTH)
//   PRESCALE  4   enabled clocks per Output1 increment (>=2)
// PORTS
//   Clk      in   1      single clock, all state updates on rising edge
//   Reset    in   1      asynchronous, active-low reset (Reset==0 clears all state)
//   Slt      in   1      channel select: 0 -> Output0 channel, 1 -> Output1 channel
//   En       in   1      count enable; 0 holds all state
//   Output0  out  WIDTH  fast counter value (registered)
//   Output1  out  WIDTH  prescaled counter value (registered)
// BEHAVIOUR
//   - Reset low: Output0=0, Output1=0, prescaler=0 immediately, independent of Clk;
//     held while low. First count can occur on the first rising edge after release.
//   - Each rising edge with Reset high:
//       En=0            : nothing changes (prescaler also holds).
//       En=1, Slt=0     : Output0 <= Output0+1; Output1 and prescaler hold.
//       En=1, Slt=1     : if prescaler==PRESCALE-1 then Output1 <= Output1+1 and
//                         prescaler <= 0, else prescaler <= prescaler+1; Output0 holds.
//   - Outputs are direct register values; increment visible right after the edge
//     (latency 1 cycle from the enabling edge).
//   - Switching Slt does not clear the prescaler: partial progress is retained and
//     resumes when Slt returns to 1.
//   - Wrap-around: all-ones +1 -> 0 on either channel, no flag, no saturation.
//   - Slt/En sampled only at the edge; glitches between edges have no effect.
//   - Prescaler width = $clog2(PRESCALE); not exported.
// STRUCTURE
//   - Shared package code_pkg: localparam CODE_WIDTH=64, CODE_PRESCALE=4, and
//     channel-select enum {CH_FAST=1'b0, CH_DIV=1'b1}.
//   - One sub-module code_cnt: WIDTH-bit up-counter with async active-low clear and
//     inc enable; instantiated twice (Output0, Output1). Prescaler and select
//     decode live in the top.
// TESTING
//   - Reset=0 mid-count (async, between edges) -> Output0=Output1=0 at once; after
//     release, Slt=1 needs a full 4 enabled edges before Output1=1.
//   - Reset released, En=1, Slt=0, 10 edges -> Output0=10, Output1=0.
//   - En=1, Slt=1, 12 edges from reset -> Output1=3 (increments on edges 4,8,12),
//     Output0=0.
//   - Slt=1 for 2 edges, Slt=0 for 5 edges, Slt=1 for 2 edges -> Output0=5,
//     Output1=1 (prescaler retained across switch).
//   - En=0 for 20 edges with any Slt -> both outputs and prescaler unchanged.
//   - Force Output0 to 64'hFFFF_FFFF_FFFF_FFFF (via bench preload), En=1, Slt=0, 1
//     edge -> Output0=0; same wrap check on Output1 after 4 edges with Slt=1.

Source files
------------

// File: rtl/code_pkg.sv
// ---------------------------------------------------------------------------
// code_pkg
//   Shared definitions for the dual event counter.
//   - CODE_WIDTH    : default counter width
//   - CODE_PRESCALE : default number of enabled clocks per divided-channel tick
//   - channel_e     : channel-select encoding carried on the Slt input
// ---------------------------------------------------------------------------
package code_pkg;

  localparam int CODE_WIDTH    = 64;
  localparam int CODE_PRESCALE = 4;

  typedef enum logic {
    CH_FAST = 1'b0,
    CH_DIV  = 1'b1
  } channel_e;

endpackage : code_pkg

// File: rtl/code_cnt.sv
// ---------------------------------------------------------------------------
// code_cnt
//   WIDTH-bit free-running up-counter with an increment enable. It wraps
//   modulo 2^WIDTH and has no saturation or overflow flag.
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low clear
//   inc    in   1      add one on this rising edge
//   count  out  WIDTH  current counter value (direct register output)
// ---------------------------------------------------------------------------
module code_cnt #(
  parameter int WIDTH = code_pkg::CODE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (inc) begin
      count_next = count_reg + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule : code_cnt

// File: rtl/code_counter.sv
// ---------------------------------------------------------------------------
// code_counter
//   Dual event counter. Output0 counts every enabled clock on the fast
//   channel; Output1 counts once per PRESCALE enabled clocks on the divided
//   channel. Slt picks which channel an enabled clock is credited to; En gates
//   all counting, including the prescaler.
// Ports
//   Clk      in   1      rising-edge clock
//   Reset    in   1      asynchronous active-low reset of all state
//   Slt      in   1      0 = fast channel (Output0), 1 = divided channel (Output1)
//   En       in   1      count enable; 0 holds all state
//   Output0  out  WIDTH  fast counter value
//   Output1  out  WIDTH  prescaled counter value
// ---------------------------------------------------------------------------
module code_counter
  import code_pkg::*;
#(
  parameter int WIDTH    = CODE_WIDTH,
  parameter int PRESCALE = CODE_PRESCALE
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Slt,
  input  logic             En,
  output logic [WIDTH-1:0] Output0,
  output logic [WIDTH-1:0] Output1
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  channel_e sel;
  logic     fast_inc;
  logic     div_active;
  logic     div_inc;

  logic [PW-1:0] presc_reg;
  logic [PW-1:0] presc_next;

  assign sel        = channel_e'(Slt);
  assign fast_inc   = En && (sel == CH_FAST);
  assign div_active = En && (sel == CH_DIV);
  // Output1 advances on the enabled divided-channel clock that completes a
  // full prescale period.
  assign div_inc    = div_active && (presc_reg == PRESC_LAST);

  // The prescaler only moves while the divided channel is active, so a
  // partial period survives a detour to the fast channel or a pause in En.
  always_comb begin
    presc_next = presc_reg;
    if (div_active) begin
      if (presc_reg == PRESC_LAST) begin
        presc_next = '0;
      end else begin
        presc_next = presc_reg + PW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_next;
    end
  end

  code_cnt #(
    .WIDTH (WIDTH)
  ) u_fast (
    .clk   (Clk),
    .rst_n (Reset),
    .inc   (fast_inc),
    .count (Output0)
  );

  code_cnt #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk   (Clk),
    .rst_n (Reset),
    .inc   (div_inc),
    .count (Output1)
  );

endmodule : code_counter

// File: tb/tb_code_counter.sv
// ---------------------------------------------------------------------------
// tb_code_counter
//   Self-checking bench for code_counter. A 64-bit instance exercises the
//   counting rules; a 4-bit instance sharing the same inputs makes the
//   all-ones -> zero wrap reachable in a handful of edges.
// ---------------------------------------------------------------------------
module tb_code_counter;

  logic        clk;
  logic        rst_n;
  logic        slt;
  logic        en;
  logic [63:0] out0;
  logic [63:0] out1;
  logic [3:0]  small_out0;
  logic [3:0]  small_out1;

  int errors = 0;
  int checks = 0;

  code_counter #(
    .WIDTH    (64),
    .PRESCALE (4)
  ) dut (
    .Clk     (clk),
    .Reset   (rst_n),
    .Slt     (slt),
    .En      (en),
    .Output0 (out0),
    .Output1 (out1)
  );

  code_counter #(
    .WIDTH    (4),
    .PRESCALE (4)
  ) dut_small (
    .Clk     (clk),
    .Reset   (rst_n),
    .Slt     (slt),
    .En      (en),
    .Output0 (small_out0),
    .Output1 (small_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          do_rst;
    bit          en;
    bit          slt;
    int          edges;
    logic [63:0] exp0;
    logic [63:0] exp1;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  // Hold reset across two edges (with En high) and release it at a falling edge.
  task automatic do_reset();
    en    = 1'b1;
    slt   = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    slt   = 1'b0;

    // {do_rst, en, slt, edges, exp Output0, exp Output1}
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 10, 64'd10, 64'd0};  // fast channel, 10 edges
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 12, 64'd0,  64'd3};  // divided channel, 12 edges
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 2,  64'd0,  64'd0};  // half a period
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 5,  64'd5,  64'd0};  // detour to fast channel
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 2,  64'd5,  64'd1};  // prescaler progress retained
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 3,  64'd5,  64'd1};  // prescaler now at 3
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 20, 64'd5,  64'd1};  // En=0 holds, Slt=1
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 20, 64'd5,  64'd1};  // En=0 holds, Slt=0
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1,  64'd5,  64'd2};  // held prescaler completes
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1,  64'd6,  64'd2};  // single fast edge
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1,  64'd0,  64'd0};  // one divided edge, no tick
    vecs[11] = '{1'b0, 1'b1, 1'b1, 7,  64'd0,  64'd2};  // 8 divided edges total

    // Reset state
    do_reset();
    check("reset_out0", out0, 64'd0);
    check("reset_out1", out1, 64'd0);

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].do_rst) do_reset();
      en  = vecs[i].en;
      slt = vecs[i].slt;
      run_edges(vecs[i].edges);
      check($sformatf("vec%0d_out0", i), out0, vecs[i].exp0);
      check($sformatf("vec%0d_out1", i), out1, vecs[i].exp1);
    end

    // Asynchronous reset asserted between edges clears at once.
    do_reset();
    en  = 1'b1;
    slt = 1'b0;
    run_edges(7);
    slt = 1'b1;
    run_edges(6);
    check("pre_async_out0", out0, 64'd7);
    check("pre_async_out1", out1, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clr_out0", out0, 64'd0);
    check("async_clr_out1", out1, 64'd0);
    run_edges(3);
    check("held_rst_out1", out1, 64'd0);
    rst_n = 1'b1;
    // A fresh full period of 4 enabled edges is needed after release.
    for (int k = 1; k <= 4; k++) begin
      run_edges(1);
      check($sformatf("post_rst_edge%0d_out1", k), out1, (k == 4) ? 64'd1 : 64'd0);
    end
    check("post_rst_out0", out0, 64'd0);

    // Wrap-around on the 4-bit instance: fast channel.
    do_reset();
    en  = 1'b1;
    slt = 1'b0;
    run_edges(15);
    check("wrap_fast_allones", {60'd0, small_out0}, 64'hF);
    run_edges(1);
    check("wrap_fast_zero", {60'd0, small_out0}, 64'h0);
    check("wrap_fast_big_out0", out0, 64'd16);

    // Wrap-around on the 4-bit instance: divided channel.
    slt = 1'b1;
    run_edges(60);
    check("wrap_div_allones", {60'd0, small_out1}, 64'hF);
    run_edges(3);
    check("wrap_div_not_yet", {60'd0, small_out1}, 64'hF);
    run_edges(1);
    check("wrap_div_zero", {60'd0, small_out1}, 64'h0);
    check("wrap_div_big_out1", out1, 64'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_code_counter
